// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and types for the dmem_responder slice.
//   F3_*      RV32I load/store funct3 encodings
//   WAIT_MAX  largest supported WAIT_STATES value
//   state_t   responder FSM state
//   size_t    access width decoded from funct3
//   req_t     latched request fields (address kept separately, it is sized by DEPTH)
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int WAIT_MAX = 15;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  typedef struct packed {
    logic        write;
    logic [2:0]  funct3;
    logic [31:0] wdata;
  } req_t;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational lane steering for one 32-bit word access.
//   funct3, addr_lo  access type and byte offset within the word
//   wdata            right-aligned store data
//   rword            current array word
//   be, wdata_sh     store byte enables and lane-replicated store data
//   rdata            extended load data
//   misalign         trap flag (only when DMEM_MISALIGN_TRAP_EN is defined)
// With DMEM_MISALIGN_TRAP_EN undefined, misaligned offsets are forced to the
// natural alignment and unsupported funct3 behaves as a word access.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata,
  output logic        misalign
);
  size_t       sz;
  logic        uns;
  logic [1:0]  off;
  logic [31:0] sh;

  always_comb begin
    case (funct3)
      F3_B, F3_BU: sz = SZ_B;
      F3_H, F3_HU: sz = SZ_H;
      default:     sz = SZ_W;
    endcase
  end

  assign uns = (funct3 == F3_BU) || (funct3 == F3_HU);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign off      = addr_lo;
  assign misalign = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) ||
                    ((sz == SZ_H) && addr_lo[0]) ||
                    ((sz == SZ_W) && (addr_lo != 2'b00));
`else
  always_comb begin
    case (sz)
      SZ_B:    off = addr_lo;
      SZ_H:    off = {addr_lo[1], 1'b0};
      default: off = 2'b00;
    endcase
  end
  assign misalign = 1'b0;
`endif

  // addressed lane brought down to bit 0
  assign sh = rword >> {off, 3'b000};

  always_comb begin
    be       = 4'b0000;
    wdata_sh = wdata;
    rdata    = 32'h0;
    case (sz)
      SZ_B: begin
        be       = 4'b0001 << off;
        wdata_sh = {4{wdata[7:0]}};
        rdata    = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      end
      SZ_H: begin
        be       = 4'b0011 << off;
        wdata_sh = {2{wdata[15:0]}};
        rdata    = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      end
      default: begin
        be       = 4'b1111;
        wdata_sh = wdata;
        rdata    = rword;
      end
    endcase
    if (misalign) begin
      be    = 4'b0000;
      rdata = 32'h0;
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder over a word array.
//   clk, reset             clock, synchronous active-high reset
//   req_valid/req_ready    request handshake; req_write, req_funct3,
//                          req_addr, req_wdata carry the access
//   rsp_valid/rsp_ready    response handshake; rsp_rdata, rsp_err
// Parameters: DEPTH_WORDS (power of two), WAIT_STATES (0..WAIT_MAX), ADDR_W derived.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned/unsupported
// accesses report rsp_err and suppress the store).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  state_t            state, state_nx;
  logic [3:0]        cnt;
  req_t              lat;
  logic [ADDR_W+1:0] lat_addr;
  logic [31:0]       mem [DEPTH_WORDS];

  logic              accept, commit;
  req_t              op;
  logic [ADDR_W+1:0] op_addr;
  logic [31:0]       rword, al_wdata, al_rdata;
  logic [3:0]        al_be;
  logic              al_misalign;

  assign accept = req_valid && req_ready;

  // With zero wait states the commit happens on the accept edge itself,
  // so the operands come straight from the request port in IDLE.
  assign op      = (state == IDLE) ? '{write: req_write, funct3: req_funct3, wdata: req_wdata} : lat;
  assign op_addr = (state == IDLE) ? req_addr[ADDR_W+1:0] : lat_addr;
  assign rword   = mem[op_addr[ADDR_W+1:2]];

  // Gated by reset so a store due on a reset edge is dropped.
  assign commit = !reset && (state != RESP) && (state_nx == RESP);

  dmem_lane_align u_align (
    .funct3   (op.funct3),
    .addr_lo  (op_addr[1:0]),
    .wdata    (op.wdata),
    .rword    (rword),
    .be       (al_be),
    .wdata_sh (al_wdata),
    .rdata    (al_rdata),
    .misalign (al_misalign)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = (WAIT_STATES == 0) ? RESP : BUSY;
      BUSY:    if (cnt == 4'd0) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // state-decoded outputs; reset masks ready before the state register clears
  always_comb begin
    req_ready = (state == IDLE) && !reset;
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= 4'd0;
      lat      <= '0;
      lat_addr <= '0;
    end else begin
      if (accept) begin
        lat      <= op;
        lat_addr <= op_addr;
        cnt      <= (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // array is deliberately not reset
  always_ff @(posedge clk) begin
    if (commit && op.write) begin
      for (int b = 0; b < 4; b++)
        if (al_be[b]) mem[op_addr[ADDR_W+1:2]][8*b +: 8] <= al_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       rsp_rdata <= 32'h0;
    else if (commit) rsp_rdata <= op.write ? 32'h0 : al_rdata;
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset)       rsp_err <= 1'b0;
    else if (commit) rsp_err <= al_misalign;
  end
  logic unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_W+2];
`else
  assign rsp_err = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{req_addr[31:ADDR_W+2], al_misalign};
`endif
endmodule
